// File: rtl/vga_out_stage_if.sv
// vga_out_stage_if: colour-in / coordinate-out / pin-out bundle of the VGA output stage.
interface vga_out_stage_if;
    logic       red_in, green_in, blue_in;
    logic [9:0] pix_x, pix_y;
    logic       pix_valid, frame_start;
    logic       hsync, vsync, vga_r, vga_g, vga_b;
    modport master (
        input  red_in, green_in, blue_in,
        output pix_x, pix_y, pix_valid, frame_start, hsync, vsync, vga_r, vga_g, vga_b
    );
    modport slave (
        output red_in, green_in, blue_in,
        input  pix_x, pix_y, pix_valid, frame_start, hsync, vsync, vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/vga_out_stage.sv
// vga_out_stage: 640x480 raster timing plus registered sync/colour pins, one pixel behind the published coordinate.
module vga_out_stage #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2
) (
    input logic clk,
    input logic rst,
    vga_out_stage_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [DW-1:0] div;
    logic [9:0]    h_cnt, v_cnt;
    logic          pix_ce, h_last, v_last, active, h_sync_on, v_sync_on;
    assign pix_ce    = div == DW'(CLK_DIV - 1);
    assign h_last    = h_cnt == 10'(H_TOTAL - 1);
    assign v_last    = v_cnt == 10'(V_TOTAL - 1);
    assign active    = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
    assign h_sync_on = (h_cnt >= 10'(H_ACTIVE + H_FP)) && (h_cnt < 10'(H_ACTIVE + H_FP + H_SYNC));
    assign v_sync_on = (v_cnt >= 10'(V_ACTIVE + V_FP)) && (v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC));
    assign vif.pix_x       = h_cnt;
    assign vif.pix_y       = v_cnt;
    assign vif.pix_valid   = active;
    assign vif.frame_start = pix_ce && h_cnt == 10'd0 && v_cnt == 10'd0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div       <= '0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            vif.hsync <= 1'b1;
            vif.vsync <= 1'b1;
            vif.vga_r <= 1'b0;
            vif.vga_g <= 1'b0;
            vif.vga_b <= 1'b0;
        end else begin
            div <= pix_ce ? '0 : div + 1'b1;
            // pins latch the pixel the counters point at, so they trail the coordinate by one pixel
            if (pix_ce) begin
                h_cnt     <= h_last ? '0 : h_cnt + 10'd1;
                v_cnt     <= h_last ? (v_last ? '0 : v_cnt + 10'd1) : v_cnt;
                vif.hsync <= ~h_sync_on;
                vif.vsync <= ~v_sync_on;
                vif.vga_r <= active & vif.red_in;
                vif.vga_g <= active & vif.green_in;
                vif.vga_b <= active & vif.blue_in;
            end
        end
    end
endmodule
